ti_kbd_matrix: RTL



---
 rtl/ti_kbd_matrix.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ti_kbd_matrix.sv
// PS/2 key events to TI-99/4A 8x8 keyboard matrix with alpha-lock and a timed
// FCTN-first sequencer for composed keys. Define TI_KBD_ARROW_FCTN_EN to map arrows to FCTN+E/X/S/D.
module ti_kbd_matrix #(
  parameter int SETTLE_CYC = 85000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [10:0] ps2_key_i,
  input  logic [8:0]  sel_n_i,
  output logic [7:0]  keys_n_o,
  output logic        alpha_lock_o,
  output logic        overflow_o,
  output logic        busy_o
);

  localparam int         PW       = $clog2(FIFO_DEPTH);
  localparam int         CW       = $clog2(SETTLE_CYC + 1);
  localparam logic [5:0] FCTN_IDX = 6'd39;

  typedef enum logic [2:0] {S_IDLE, S_MOD_ON, S_KEY_ON, S_HOLD, S_KEY_OFF, S_MOD_OFF} state_t;
  typedef enum logic [1:0] {K_NONE, K_DIRECT, K_COMPOSED, K_CAPS} kind_t;
  typedef struct packed {
    kind_t      kind;
    logic [5:0] idx;
  } look_t;

  function automatic look_t mk(kind_t k, int c, int b);
    mk.kind = k;
    mk.idx  = 6'(c * 8 + b);
  endfunction

  function automatic look_t lookup(logic ext, logic [7:0] code);
    lookup = mk(K_NONE, 0, 0);
    if (!ext) begin
      case (code)
        8'h2E: lookup = mk(K_DIRECT, 0, 0);   // 5
        8'h25: lookup = mk(K_DIRECT, 0, 1);   // 4
        8'h26: lookup = mk(K_DIRECT, 0, 2);   // 3
        8'h1E: lookup = mk(K_DIRECT, 0, 3);   // 2
        8'h36: lookup = mk(K_DIRECT, 0, 4);
        8'h3D: lookup = mk(K_DIRECT, 0, 5);
        8'h3E: lookup = mk(K_DIRECT, 0, 6);
        8'h55: lookup = mk(K_DIRECT, 0, 7);
        8'h2C: lookup = mk(K_DIRECT, 1, 0);
        8'h2D: lookup = mk(K_DIRECT, 1, 1);
        8'h15: lookup = mk(K_DIRECT, 1, 2);
        8'h1D: lookup = mk(K_DIRECT, 1, 3);
        8'h35: lookup = mk(K_DIRECT, 1, 4);
        8'h3C: lookup = mk(K_DIRECT, 1, 5);
        8'h43: lookup = mk(K_DIRECT, 1, 6);
        8'h29: lookup = mk(K_DIRECT, 1, 7);   // Space
        8'h34: lookup = mk(K_DIRECT, 2, 0);
        8'h2B: lookup = mk(K_DIRECT, 2, 1);
        8'h33: lookup = mk(K_DIRECT, 2, 2);
        8'h3B: lookup = mk(K_DIRECT, 2, 3);
        8'h42: lookup = mk(K_DIRECT, 2, 4);
        8'h4B: lookup = mk(K_DIRECT, 2, 5);
        8'h4C: lookup = mk(K_DIRECT, 2, 6);
        8'h5A: lookup = mk(K_DIRECT, 2, 7);   // Enter
        8'h32: lookup = mk(K_DIRECT, 3, 0);
        8'h2A: lookup = mk(K_DIRECT, 3, 1);
        8'h21: lookup = mk(K_DIRECT, 3, 2);
        8'h31: lookup = mk(K_DIRECT, 3, 3);
        8'h3A: lookup = mk(K_DIRECT, 3, 4);
        8'h41: lookup = mk(K_DIRECT, 3, 5);
        8'h49: lookup = mk(K_DIRECT, 3, 6);
        8'h4A: lookup = mk(K_DIRECT, 3, 7);
        8'h46: lookup = mk(K_DIRECT, 4, 0);
        8'h45: lookup = mk(K_DIRECT, 4, 1);
        8'h16: lookup = mk(K_DIRECT, 4, 2);   // 1
        8'h11: lookup = mk(K_DIRECT, 4, 7);   // FCTN (LAlt)
        8'h1C: lookup = mk(K_DIRECT, 5, 2);   // A
        8'h23: lookup = mk(K_DIRECT, 5, 5);   // D
        8'h1B: lookup = mk(K_DIRECT, 5, 6);   // S
        8'h12, 8'h59: lookup = mk(K_DIRECT, 5, 7);
        8'h44: lookup = mk(K_DIRECT, 6, 0);
        8'h4D: lookup = mk(K_DIRECT, 6, 1);
        8'h24: lookup = mk(K_DIRECT, 6, 5);   // E
        8'h14: lookup = mk(K_DIRECT, 6, 7);   // CTRL (LCtrl)
        8'h1A: lookup = mk(K_DIRECT, 7, 0);
        8'h22: lookup = mk(K_DIRECT, 7, 6);   // X
        8'h66: lookup = mk(K_COMPOSED, 5, 6); // Backspace -> FCTN+S
        8'h58: lookup = mk(K_CAPS, 0, 0);
        default: ;
      endcase
    end
`ifdef TI_KBD_ARROW_FCTN_EN
    else begin
      case (code)
        8'h75: lookup = mk(K_COMPOSED, 6, 5);
        8'h72: lookup = mk(K_COMPOSED, 7, 6);
        8'h6B: lookup = mk(K_COMPOSED, 5, 6);
        8'h74: lookup = mk(K_COMPOSED, 5, 5);
        default: ;
      endcase
    end
`endif
  endfunction

  logic [9:0]    r_fifo [FIFO_DEPTH];
  logic [PW:0]   r_wr_ptr, r_rd_ptr;
  logic          r_toggle, r_armed;
  logic          r_overflow, r_alpha, r_vmod;
  logic [63:0]   r_matrix;
  logic [7:0]    r_keys_n;
  logic [CW-1:0] r_cnt;
  logic [5:0]    r_base_idx;
  logic [8:0]    r_comp_key;
  state_t        r_state;

  state_t     w_state_nx;
  logic       w_event, w_full, w_empty, w_push, w_pop;
  logic [9:0] w_head;
  look_t      w_look;
  logic       w_wr_en, w_wr_val, w_caps_tgl, w_comp_load, w_vmod_nx, w_cnt_clr, w_settled;
  logic [5:0] w_wr_idx;
  logic [63:0] w_eff;
  logic [7:0] w_keys;

  // Toggle compare is gated until the first post-reset clock has sampled the input.
  assign w_event = r_armed & (ps2_key_i[10] ^ r_toggle);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = ((r_wr_ptr ^ r_rd_ptr) == {1'b1, {PW{1'b0}}});
  assign w_push  = w_event & (~w_full | w_pop);
  assign w_head  = r_fifo[r_rd_ptr[PW-1:0]];
  assign w_look  = lookup(w_head[8], w_head[7:0]);
  assign w_settled = (r_cnt == CW'(SETTLE_CYC - 1));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nx  = r_state;
    w_pop       = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_idx    = w_look.idx;
    w_wr_val    = w_head[9];
    w_caps_tgl  = 1'b0;
    w_comp_load = 1'b0;
    w_vmod_nx   = r_vmod;
    w_cnt_clr   = 1'b0;
    case (r_state)
      S_IDLE, S_HOLD: begin
        if (!w_empty) begin
          case (w_look.kind)
            K_DIRECT: begin w_pop = 1'b1; w_wr_en = 1'b1; end
            K_CAPS:   begin w_pop = 1'b1; w_caps_tgl = w_head[9]; end
            K_COMPOSED: begin
              if (r_state == S_IDLE) begin
                w_pop = 1'b1;
                if (w_head[9]) begin
                  w_comp_load = 1'b1;
                  w_vmod_nx   = 1'b1;
                  w_cnt_clr   = 1'b1;
                  w_state_nx  = S_MOD_ON;
                end
              end else if (w_head[8:0] == r_comp_key) begin
                // Typematic repeats of the held key are swallowed; its release starts teardown.
                w_pop = 1'b1;
                if (!w_head[9]) begin
                  w_wr_en    = 1'b1;
                  w_wr_idx   = r_base_idx;
                  w_wr_val   = 1'b0;
                  w_cnt_clr  = 1'b1;
                  w_state_nx = S_KEY_OFF;
                end
              end else if (!w_head[9]) begin
                w_pop = 1'b1;
              end
            end
            default: w_pop = 1'b1;
          endcase
        end
      end
      S_MOD_ON: if (w_settled) begin
        w_wr_en    = 1'b1;
        w_wr_idx   = r_base_idx;
        w_wr_val   = 1'b1;
        w_state_nx = S_KEY_ON;
      end
      S_KEY_ON: w_state_nx = S_HOLD;
      S_KEY_OFF: if (w_settled) begin
        w_vmod_nx  = 1'b0;
        w_state_nx = S_MOD_OFF;
      end
      S_MOD_OFF: w_state_nx = S_IDLE;
      default:   w_state_nx = S_IDLE;
    endcase
  end

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wr_ptr[PW-1:0]] <= ps2_key_i[9:0];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_toggle   <= 1'b0;
      r_armed    <= 1'b0;
      r_overflow <= 1'b0;
      r_alpha    <= 1'b0;
      r_vmod     <= 1'b0;
      r_matrix   <= '0;
      r_keys_n   <= 8'hFF;
      r_cnt      <= '0;
      r_base_idx <= '0;
      r_comp_key <= '0;
      r_state    <= S_IDLE;
    end else begin
      r_toggle <= ps2_key_i[10];
      r_armed  <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_event && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_caps_tgl) r_alpha <= ~r_alpha;
      if (w_wr_en) r_matrix[w_wr_idx] <= w_wr_val;
      if (w_comp_load) begin
        r_base_idx <= w_look.idx;
        r_comp_key <= w_head[8:0];
      end
      if (w_cnt_clr) r_cnt <= '0;
      else if (r_state == S_MOD_ON || r_state == S_KEY_OFF) r_cnt <= r_cnt + CW'(1);
      r_vmod   <= w_vmod_nx;
      r_state  <= w_state_nx;
      r_keys_n <= ~w_keys;
    end
  end

  // Virtual FCTN is ORed in, so a physical FCTN release during HOLD keeps it asserted.
  assign w_eff = r_matrix | ({63'd0, r_vmod} << FCTN_IDX);

  always_comb begin
    w_keys = '0;
    for (int c = 0; c < 8; c++) w_keys = w_keys | (w_eff[c*8 +: 8] & {8{~sel_n_i[c]}});
    w_keys[4] = w_keys[4] | (r_alpha & ~sel_n_i[8]);
  end

  assign keys_n_o     = r_keys_n;
  assign alpha_lock_o = r_alpha;
  assign overflow_o   = r_overflow;
  assign busy_o       = (r_state != S_IDLE) && (r_state != S_HOLD);

endmodule
